// File: rtl/ext_gcd_pkg.sv
// rtl/ext_gcd_pkg.sv - shared types and sizing helpers for the extended-Euclid engine
package ext_gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        UPDATE,
        FIX,
        DONE
    } state_t;

    // Bezout coefficients need two extra bits: one for sign, one for |s| == b.
    function automatic int s_width(input int w);
        return w + 2;
    endfunction

    // Worst-case Euclid iteration count, ceil(1.45 * w) + 2.
    function automatic int iter_bound(input int w);
        return (145 * w + 99) / 100 + 2;
    endfunction

endpackage

// File: rtl/udiv_seq.sv
// rtl/udiv_seq.sv - restoring shift-subtract unsigned divider, WIDTH-cycle latency
module udiv_seq #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;

    logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [WIDTH:0]   shifted, diff;
    logic             fits;
    logic [WIDTH-1:0] step_rem, step_quo;

    // One restoring step; on start it works straight from the inputs so the
    // first quotient bit is produced on the accepting edge.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dvs  = start ? divisor : dvs_q;
        shifted  = {src_rem, src_quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, src_dvs});
        diff     = shifted - {1'b0, src_dvs};
        step_rem = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        step_quo = {src_quo[WIDTH-2:0], fits};
    end

    // Step counter; done is raised in the cycle after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q  <= step_rem;
            quo_q  <= step_quo;
            dvs_q  <= divisor;
            cnt_q  <= CW'(WIDTH - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q  <= step_rem;
            quo_q  <= step_quo;
            cnt_q  <= cnt_q - CW'(1);
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/ext_gcd.sv
// rtl/ext_gcd.sv - extended-Euclid engine returning gcd(a, b) and a^-1 mod b
module ext_gcd
    import ext_gcd_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic [WIDTH-1:0] inv,
    output logic             inv_valid,
    output logic             err
);

    localparam int S_W = s_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, old_r_q, r_q;
    logic [S_W-1:0]   old_s_q, s_q;
    logic             div_started_q;

    logic             div_start, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic [S_W-1:0]   qs, s_next;
    logic [WIDTH-1:0] inv_fixed;

    udiv_seq #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (old_r_q),
        .divisor   (r_q),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Coefficient update and sign fix; truncation to S_W bits is exact for s,
    // and the W-bit add wraps a negative old_s into [0, b-1].
    always_comb begin
        qs        = {2'b00, div_quo} * s_q;
        s_next    = old_s_q - qs;
        inv_fixed = old_s_q[WIDTH-1:0] + (old_s_q[S_W-1] ? b_q : '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE:   if (start) state_d = CHECK;
            CHECK:  state_d = (b_q == '0) ? DONE : DIV;
            DIV: begin
                div_start = !div_started_q;
                if (div_done) state_d = UPDATE;
            end
            UPDATE: state_d = (div_rem == '0) ? FIX : DIV;
            FIX:    state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // Operand capture, remainder/coefficient sequence and result registers.
    // r takes the divider remainder, which equals old_r - q*r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            old_r_q       <= '0;
            r_q           <= '0;
            old_s_q       <= '0;
            s_q           <= '0;
            div_started_q <= 1'b0;
            gcd           <= '0;
            inv           <= '0;
            inv_valid     <= 1'b0;
            err           <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    a_q <= a;
                    b_q <= b;
                end
                CHECK: if (b_q == '0) begin
                    gcd       <= a_q;
                    inv       <= '0;
                    inv_valid <= 1'b0;
                    err       <= 1'b1;
                end else begin
                    old_r_q <= a_q;
                    r_q     <= b_q;
                    old_s_q <= S_W'(1);
                    s_q     <= '0;
                end
                DIV:    div_started_q <= !div_done;
                UPDATE: begin
                    old_r_q <= r_q;
                    r_q     <= div_rem;
                    old_s_q <= s_q;
                    s_q     <= s_next;
                end
                FIX: begin
                    gcd       <= old_r_q;
                    inv       <= inv_fixed;
                    inv_valid <= (old_r_q == WIDTH'(1));
                    err       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_gcd.sv
// tb/tb_ext_gcd.sv - directed self-checking bench for ext_gcd
module tb_ext_gcd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] a, b;
    logic        busy, done, inv_valid, err;
    logic [11:0] gcd, inv;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int done_seen;

    always #5 clk = ~clk;

    ext_gcd #(.WIDTH(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .gcd       (gcd),
        .inv       (inv),
        .inv_valid (inv_valid),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one operation; lat is the cycle (start-accept edge = 0) in which done
    // is seen, or -1 on timeout. glitch > 0 pulses start with other operands then.
    task automatic run(input logic [11:0] ia, input logic [11:0] ib, input int glitch,
                       output int latency);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        latency = -1;
        for (int n = 1; n <= 2000; n++) begin
            if (done) begin
                latency = n;
                break;
            end
            if (n == glitch) begin
                start = 1'b1; a = 12'd5; b = 12'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic after_done;
        @(negedge clk);
        check("done_single_pulse", done, 1'b0);
        check("busy_drops", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_gcd", gcd, 12'd0);
        check("rst_inv", inv, 12'd0);
        check("rst_inv_valid", inv_valid, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;

        run(12'd36, 12'd60, 0, lat);
        check("g36_60_lat", lat, 59);
        check("g36_60_gcd", gcd, 12'd12);
        check("g36_60_iv", inv_valid, 1'b0);
        check("g36_60_err", err, 1'b0);
        after_done();

        run(12'd7, 12'd40, 0, lat);
        check("g7_40_lat", lat, 73);
        check("g7_40_gcd", gcd, 12'd1);
        check("g7_40_inv", inv, 12'd23);
        check("g7_40_iv", inv_valid, 1'b1);
        after_done();

        run(12'd17, 12'd3120, 0, lat);
        check("g17_3120_timeout", (lat > 0), 1'b1);
        check("g17_3120_inv", inv, 12'd2753);
        check("g17_3120_iv", inv_valid, 1'b1);

        run(12'd4095, 12'd4094, 0, lat);
        check("g4095_timeout", (lat > 0), 1'b1);
        check("g4095_gcd", gcd, 12'd1);
        check("g4095_inv", inv, 12'd1);

        run(12'd9, 12'd0, 0, lat);
        check("b0_lat", lat, 2);
        check("b0_err", err, 1'b1);
        check("b0_gcd", gcd, 12'd9);
        check("b0_iv", inv_valid, 1'b0);
        after_done();

        run(12'd0, 12'd1, 0, lat);
        check("a0_b1_gcd", gcd, 12'd1);
        check("a0_b1_inv", inv, 12'd0);
        check("a0_b1_iv", inv_valid, 1'b1);
        check("a0_b1_err", err, 1'b0);

        run(12'd0, 12'd5, 0, lat);
        check("a0_b5_gcd", gcd, 12'd5);
        check("a0_b5_iv", inv_valid, 1'b0);

        run(12'd7, 12'd40, 10, lat);
        check("glitch_lat", lat, 73);
        check("glitch_gcd", gcd, 12'd1);
        check("glitch_inv", inv, 12'd23);
        after_done();

        // Abort a run with reset partway through.
        @(negedge clk);
        a = 12'd17; b = 12'd3120; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_abort_busy", busy, 1'b1);
        rst_n = 1'b0;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_gcd", gcd, 12'd0);
        check("abort_inv", inv, 12'd0);
        check("abort_iv", inv_valid, 1'b0);
        check("abort_err", err, 1'b0);

        run(12'd3, 12'd7, 0, lat);
        check("post_abort_timeout", (lat > 0), 1'b1);
        check("post_abort_inv", inv, 12'd5);
        check("post_abort_iv", inv_valid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
